// File: rtl/common_types_pkg.sv
// Shared types for the UART transmit arbiter.
package common_types_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_START,
        ARB_BUSY
    } uart_arb_state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: first set request after ptr, searching upward with wrap.
module rr_priority_pick #(
    parameter int NUM_REQ = 4,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt_oh,
    output logic [IW-1:0]      gnt_idx
);

    always_comb begin : pick
        logic        found;
        int unsigned k;
        found   = 1'b0;
        k       = 0;
        gnt_oh  = '0;
        gnt_idx = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            k = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[k]) begin
                found     = 1'b1;
                gnt_oh[k] = 1'b1;
                gnt_idx   = IW'(k);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx between NUM_REQ byte requesters.
// Define UART_ARB_LOCK_EN to let req_lock keep the grant for a packet.
module uart_tx_arbiter
    import common_types_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_lock,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [UART_BYTE_W-1:0]         tx_data,
    output logic                           tx_start,
    input  logic                           tx_busy,
    input  logic                           tx_done,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           arb_busy,
    output logic                           err_timeout
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(START_TIMEOUT);

    uart_arb_state_t        state_q, state_d;
    logic [UART_BYTE_W-1:0] data_q, data_d;
    logic [IW-1:0]          grant_q, grant_d;
    logic [IW-1:0]          ptr_q, ptr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic [NUM_REQ-1:0]     cand;
    logic [NUM_REQ-1:0]     pick_oh;
    logic [IW-1:0]          pick_idx;

`ifdef UART_ARB_LOCK_EN
    logic lock_q, lock_d;
    logic lock_hold;

    // Lock lapses as soon as the owner lowers req_lock while idle.
    assign lock_hold = lock_q & req_lock[grant_q];
    assign cand = lock_hold ? (req_valid & (NUM_REQ'(1) << grant_q))
                            : req_valid;
`else
    logic unused_lock;

    assign unused_lock = ^req_lock;
    assign cand        = req_valid;
`endif

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req     (cand),
        .ptr     (ptr_q),
        .gnt_oh  (pick_oh),
        .gnt_idx (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        req_ready = '0;
`ifdef UART_ARB_LOCK_EN
        lock_d    = lock_q;
`endif
        unique case (state_q)
            ARB_IDLE: begin
                req_ready = rst ? '0 : pick_oh;
`ifdef UART_ARB_LOCK_EN
                lock_d = lock_hold;
`endif
                if (|pick_oh) begin
                    data_d  = req_data[UART_BYTE_W*int'(pick_idx) +: UART_BYTE_W];
                    grant_d = pick_idx;
                    ptr_d   = pick_idx;
                    cnt_d   = '0;
                    state_d = ARB_START;
`ifdef UART_ARB_LOCK_EN
                    lock_d  = 1'b0;
`endif
                end
            end
            ARB_START: begin
                cnt_d = cnt_q + 1'b1;
                if (tx_busy) begin
                    state_d = ARB_BUSY;
                end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ARB_IDLE;
                end
            end
            ARB_BUSY: begin
                if (tx_done) begin
                    state_d = ARB_IDLE;
`ifdef UART_ARB_LOCK_EN
                    lock_d  = req_lock[grant_q];
`endif
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            data_q  <= '0;
            grant_q <= '0;
            ptr_q   <= IW'(NUM_REQ - 1);
            cnt_q   <= '0;
            err_q   <= 1'b0;
`ifdef UART_ARB_LOCK_EN
            lock_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`ifdef UART_ARB_LOCK_EN
            lock_q  <= lock_d;
`endif
        end
    end

    assign tx_start    = (state_q == ARB_START);
    assign tx_data     = data_q;
    assign grant_id    = grant_q;
    assign arb_busy    = (state_q != ARB_IDLE);
    assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter against a round-robin reference model.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int ST = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_lock = '0;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           tx_start;
    logic           tx_busy = 1'b0;
    logic           tx_done = 1'b0;
    logic [1:0]     grant_id;
    logic           arb_busy;
    logic           err_timeout;

    int vectors     = 0;
    int miscompares = 0;
    int model_last  = N - 1;

    uart_tx_arbiter #(
        .NUM_REQ       (N),
        .START_TIMEOUT (ST)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_lock    (req_lock),
        .req_ready   (req_ready),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .grant_id    (grant_id),
        .arb_busy    (arb_busy),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic int exp_pick(input logic [N-1:0] v, input int last);
        for (int s = 1; s <= N; s++)
            if (v[(last + s) % N]) return (last + s) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] r;
        r = '0;
        if (i >= 0) r[i] = 1'b1;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_lock  = '0;
        tx_busy   = 1'b0;
        tx_done   = 1'b0;
        tick();
        tick();
        rst        = 1'b0;
        model_last = N - 1;
    endtask

    // uart_tx stand-in: accept start at once, one busy cycle, then done.
    task automatic finish_frame();
        tx_busy = 1'b1;
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tx_busy = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = '1;
        req_data  = $urandom;
        #1;
        vectors++;
        if (req_ready !== '0) begin
            miscompares++;
            $display("FAIL reset_ready: got %b want 0000", req_ready);
        end
        tick();
        tick();
        req_valid = '0;
        rst       = 1'b0;
        vectors++;
        if (tx_start !== 1'b0 || tx_data !== 8'h00 || grant_id !== 2'd0 ||
            arb_busy !== 1'b0 || err_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: start=%b data=%h id=%0d busy=%b err=%b want all 0",
                     tx_start, tx_data, grant_id, arb_busy, err_timeout);
        end
        model_last = N - 1;
    endtask

    task automatic test_single();
        req_valid = 4'b0001;
        req_data  = {24'($urandom), 8'h55};
        #1;
        vectors++;
        if (req_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL single_ready: got %b want 0001", req_ready);
        end
        tick();
        req_valid = '0;
        vectors++;
        if (tx_start !== 1'b1 || tx_data !== 8'h55 || grant_id !== 2'd0 ||
            req_ready !== '0) begin
            miscompares++;
            $display("FAIL single_start: start=%b data=%h id=%0d ready=%b want 1 55 0 0000",
                     tx_start, tx_data, grant_id, req_ready);
        end
        tx_busy = 1'b1;
        tick();
        vectors++;
        if (tx_start !== 1'b0 || tx_data !== 8'h55 || arb_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_busy: start=%b data=%h busy=%b want 0 55 1",
                     tx_start, tx_data, arb_busy);
        end
        tick();
        tx_busy = 1'b0;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        vectors++;
        if (arb_busy !== 1'b0 || tx_start !== 1'b0) begin
            miscompares++;
            $display("FAIL single_done: busy=%b start=%b want 0 0", arb_busy, tx_start);
        end
        model_last = 0;
    endtask

    task automatic test_fairness();
        int e;
        do_reset();
        req_valid = 4'b1111;
        req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        for (int f = 0; f < 5; f++) begin
            e = exp_pick(req_valid, model_last);
            #1;
            vectors++;
            if (req_ready !== onehot(e) || e != f % N) begin
                miscompares++;
                $display("FAIL fair_ready[%0d]: got %b want %b", f, req_ready, onehot(f % N));
            end
            tick();
            model_last = e;
            vectors++;
            if (grant_id !== 2'(f % N) || tx_data !== 8'hA0 + 8'(f % N) ||
                tx_start !== 1'b1 || req_ready !== '0) begin
                miscompares++;
                $display("FAIL fair_grant[%0d]: id=%0d data=%h start=%b ready=%b want id %0d",
                         f, grant_id, tx_data, tx_start, req_ready, f % N);
            end
            finish_frame();
        end
        req_valid = '0;
    endtask

    task automatic test_random();
        logic [N-1:0] pending;
        logic [7:0]   bytes [N];
        int           e;
        int           lat;
        int           len;
        pending = '0;
        for (int i = 0; i < N; i++) bytes[i] = '0;
        for (int f = 0; f < 30; f++) begin
            for (int i = 0; i < N; i++)
                if (!pending[i] && $urandom_range(0, 1) == 1) begin
                    pending[i] = 1'b1;
                    bytes[i]   = 8'($urandom);
                end
            if (pending == '0) begin
                e          = $urandom_range(0, N - 1);
                pending[e] = 1'b1;
                bytes[e]   = 8'($urandom);
            end
            req_valid = pending;
            for (int i = 0; i < N; i++) req_data[8*i +: 8] = bytes[i];
            #1;
            e = exp_pick(pending, model_last);
            vectors++;
            if (req_ready !== onehot(e)) begin
                miscompares++;
                $display("FAIL rand_ready[%0d]: got %b want %b", f, req_ready, onehot(e));
            end
            tick();
            pending[e] = 1'b0;
            req_valid  = pending;
            model_last = e;
            vectors++;
            if (tx_start !== 1'b1 || tx_data !== bytes[e] || grant_id !== 2'(e)) begin
                miscompares++;
                $display("FAIL rand_grant[%0d]: start=%b data=%h id=%0d want 1 %h %0d",
                         f, tx_start, tx_data, grant_id, bytes[e], e);
            end
            lat = $urandom_range(0, 3);
            for (int c = 0; c < lat; c++) begin
                tick();
                vectors++;
                if (tx_start !== 1'b1 || req_ready !== '0) begin
                    miscompares++;
                    $display("FAIL rand_hold[%0d]: start=%b ready=%b want 1 0000",
                             f, tx_start, req_ready);
                end
            end
            tx_busy = 1'b1;
            tick();
            vectors++;
            if (tx_start !== 1'b0 || tx_data !== bytes[e]) begin
                miscompares++;
                $display("FAIL rand_busy[%0d]: start=%b data=%h want 0 %h",
                         f, tx_start, tx_data, bytes[e]);
            end
            len = $urandom_range(0, 4);
            for (int c = 0; c < len; c++) begin
                tick();
                vectors++;
                if (req_ready !== '0 || arb_busy !== 1'b1 || tx_data !== bytes[e]) begin
                    miscompares++;
                    $display("FAIL rand_frame[%0d]: ready=%b busy=%b data=%h want 0000 1 %h",
                             f, req_ready, arb_busy, tx_data, bytes[e]);
                end
            end
            tx_done = 1'b1;
            tx_busy = 1'($urandom_range(0, 1));
            tick();
            tx_done = 1'b0;
            tx_busy = 1'b0;
            vectors++;
            if (arb_busy !== 1'b0 || tx_start !== 1'b0) begin
                miscompares++;
                $display("FAIL rand_done[%0d]: busy=%b start=%b want 0 0",
                         f, arb_busy, tx_start);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_timeout();
        int c;
        do_reset();
        req_valid = 4'b0011;
        req_data  = {16'h0000, 8'h22, 8'h11};
        #1;
        vectors++;
        if (req_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL to_ready: got %b want 0001", req_ready);
        end
        tick();
        req_valid = 4'b0010;
        vectors++;
        if (tx_start !== 1'b1 || tx_data !== 8'h11) begin
            miscompares++;
            $display("FAIL to_start: start=%b data=%h want 1 11", tx_start, tx_data);
        end
        c = 1;
        while (err_timeout !== 1'b1 && c < ST + 4) begin
            tick();
            c++;
        end
        vectors++;
        if (c - 1 != ST || arb_busy !== 1'b0 || tx_start !== 1'b0 ||
            req_ready !== 4'b0010) begin
            miscompares++;
            $display("FAIL to_pulse: after %0d cycles busy=%b start=%b ready=%b want %0d 0 0 0010",
                     c - 1, arb_busy, tx_start, req_ready, ST);
        end
        tick();
        req_valid = '0;
        vectors++;
        if (err_timeout !== 1'b0 || tx_start !== 1'b1 || grant_id !== 2'd1 ||
            tx_data !== 8'h22) begin
            miscompares++;
            $display("FAIL to_next: err=%b start=%b id=%0d data=%h want 0 1 1 22",
                     err_timeout, tx_start, grant_id, tx_data);
        end
        finish_frame();
        model_last = 1;
    endtask

    task automatic test_reset_busy();
        do_reset();
        req_valid = 4'b0100;
        req_data  = {8'h00, 8'h77, 16'h0000};
        #1;
        vectors++;
        if (req_ready !== 4'b0100) begin
            miscompares++;
            $display("FAIL rb_ready: got %b want 0100", req_ready);
        end
        tick();
        req_valid = '0;
        tx_busy   = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (tx_start !== 1'b0 || tx_data !== 8'h00 || arb_busy !== 1'b0 ||
            grant_id !== 2'd0) begin
            miscompares++;
            $display("FAIL rb_state: start=%b data=%h busy=%b id=%0d want 0 00 0 0",
                     tx_start, tx_data, arb_busy, grant_id);
        end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tx_busy = 1'b0;
        vectors++;
        if (arb_busy !== 1'b0 || tx_start !== 1'b0 || req_ready !== '0) begin
            miscompares++;
            $display("FAIL rb_late_done: busy=%b start=%b ready=%b want 0 0 0000",
                     arb_busy, tx_start, req_ready);
        end
        model_last = N - 1;
        req_valid  = 4'b0110;
        #1;
        vectors++;
        if (req_ready !== onehot(exp_pick(req_valid, model_last))) begin
            miscompares++;
            $display("FAIL rb_pointer: got %b want %b",
                     req_ready, onehot(exp_pick(req_valid, model_last)));
        end
        tick();
        req_valid  = '0;
        model_last = 1;
        finish_frame();
    endtask

    task automatic test_done_busy();
        req_valid = 4'b1000;
        req_data  = {8'h3C, 24'h000000};
        tick();
        req_valid = '0;
        tx_busy   = 1'b1;
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        vectors++;
        if (arb_busy !== 1'b0 || tx_start !== 1'b0 || tx_data !== 8'h3C) begin
            miscompares++;
            $display("FAIL db_idle: busy=%b start=%b data=%h want 0 0 3c",
                     arb_busy, tx_start, tx_data);
        end
        tick();
        tx_busy = 1'b0;
        vectors++;
        if (arb_busy !== 1'b0 || tx_start !== 1'b0) begin
            miscompares++;
            $display("FAIL db_no_restart: busy=%b start=%b want 0 0", arb_busy, tx_start);
        end
        model_last = 3;
    endtask

`ifdef UART_ARB_LOCK_EN
    task automatic test_lock();
        do_reset();
        req_valid = 4'b0001;
        req_data  = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        tick();
        req_valid = '0;
        finish_frame();
        req_valid = 4'b0111;
        req_lock  = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            #1;
            vectors++;
            if (req_ready !== 4'b0010) begin
                miscompares++;
                $display("FAIL lock_ready[%0d]: got %b want 0010", k, req_ready);
            end
            tick();
            vectors++;
            if (grant_id !== 2'd1 || tx_data !== 8'hD1) begin
                miscompares++;
                $display("FAIL lock_grant[%0d]: id=%0d data=%h want 1 d1", k, grant_id, tx_data);
            end
            if (k == 2) req_lock = '0;
            finish_frame();
        end
        #1;
        vectors++;
        if (req_ready !== 4'b0100) begin
            miscompares++;
            $display("FAIL lock_release: got %b want 0100", req_ready);
        end
        tick();
        req_valid = '0;
        finish_frame();
        model_last = 2;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_random();
        test_timeout();
        test_reset_busy();
        test_done_busy();
`ifdef UART_ARB_LOCK_EN
        test_lock();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
